// File: rtl/led_pkg.sv
// Shared definitions for the LED strip output path.
//   ser_state_t : serializer FSM states
//   WS_*        : default WS2812 timing in clock cycles at 50 MHz
//   PIXEL_W     : width of one pixel word
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } ser_state_t;

  localparam int WS_T0H    = 20;    // 0.40 us
  localparam int WS_T1H    = 40;    // 0.80 us
  localparam int WS_TBIT   = 63;    // 1.26 us
  localparam int WS_TLATCH = 2500;  // 50 us
  localparam int PIXEL_W   = 24;

endpackage

// File: rtl/led_period_timer.sv
// Free-running period counter shared by the bit and latch phases.
//   clk     : system clock
//   reset   : asynchronous active-high reset, counter to 0
//   clear   : hold the counter at 0
//   ceiling : last count of the period; counter wraps to 0 after it
//   cnt     : current count
//   wrap    : high while cnt == ceiling (final cycle of the period)
module led_period_timer #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [CW-1:0] ceiling,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap = (cnt_q == ceiling);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 single-wire serializer. Accepts 24-bit pixel words and emits them
// MSB first as pulse-width-coded bits, then a low latch period when no
// further word follows.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   pixel_data  : pixel word, bit 23 sent first
//   pixel_valid : pixel_data is valid
//   pixel_ready : serializer takes pixel_data this cycle
//   dout        : strip data line (registered)
//   busy        : high in SEND or LATCH (registered)
//   dbg_state   : current FSM state
//
// Handshake: a word moves when pixel_valid && pixel_ready on a rising edge.
// pixel_valid may be raised at any time and pixel_data is ignored while
// pixel_ready is low; pixel_ready is high in IDLE and on the last cycle of
// bit 0 so that words can stream with no gap, and is never high in reset.
module ws2812_serializer
  import led_pkg::*;
#(
  parameter int T0H    = WS_T0H,
  parameter int T1H    = WS_T1H,
  parameter int TBIT   = WS_TBIT,
  parameter int TLATCH = WS_TLATCH,
  parameter int CW     = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  output logic               dout,
  output logic               busy,
  output ser_state_t         dbg_state
);

  if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TLATCH >= 1)) begin : g_bad_timing
    $error("ws2812_serializer: illegal T0H/T1H/TBIT/TLATCH");
  end
  if (!((64'd1 << CW) > 64'(TBIT) && (64'd1 << CW) > 64'(TLATCH))) begin : g_bad_cw
    $error("ws2812_serializer: CW too small for TBIT/TLATCH");
  end

  localparam logic [CW-1:0] T0H_C       = CW'(T0H);
  localparam logic [CW-1:0] T1H_C       = CW'(T1H);
  localparam logic [CW-1:0] TBIT_M1     = CW'(TBIT - 1);
  localparam logic [CW-1:0] TLATCH_M1   = CW'(TLATCH - 1);
  localparam logic [4:0]    TOP_BIT_IDX = 5'(PIXEL_W - 1);

  ser_state_t         state_q, state_d;
  logic [PIXEL_W-1:0] shreg_q, shreg_d;
  logic [4:0]         bit_idx_q, bit_idx_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      ceiling;
  logic               wrap;
  logic               clear;
  logic               last_bit_end;
  logic               xfer;

  // One timer serves both phases: bit period in SEND, latch in LATCH.
  // Held at 0 in IDLE so the first bit starts from count 0.
  assign ceiling = (state_q == LATCH) ? TLATCH_M1 : TBIT_M1;
  assign clear   = (state_q == IDLE);

  led_period_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .ceiling (ceiling),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  assign last_bit_end = (state_q == SEND) && (bit_idx_q == 5'd0) && wrap;
  assign pixel_ready  = !reset && ((state_q == IDLE) || last_bit_end);
  assign xfer         = pixel_valid && pixel_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    dout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = SEND;
          shreg_d   = pixel_data;
          bit_idx_d = TOP_BIT_IDX;
        end
      end
      SEND: begin
        dout_d = (cnt < (shreg_q[PIXEL_W-1] ? T1H_C : T0H_C));
        if (wrap) begin
          if (bit_idx_q != 5'd0) begin
            shreg_d   = shreg_q << 1;
            bit_idx_d = bit_idx_q - 5'd1;
          end else if (xfer) begin
            shreg_d   = pixel_data;
            bit_idx_d = TOP_BIT_IDX;
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= 5'd0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: a small-timing instance
// (T0H=2, T1H=4, TBIT=6, TLATCH=10) and a default-timing instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ws2812_serializer;
  import led_pkg::*;

  localparam int S_T0H    = 2;
  localparam int S_T1H    = 4;
  localparam int S_TBIT   = 6;
  localparam int S_TLATCH = 10;
  localparam int WORD_CYC = 24 * S_TBIT;

  logic        clk;
  logic        reset;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        dout;
  logic        busy;
  ser_state_t  dbg_state;

  logic [23:0] d_data;
  logic        d_valid;
  logic        d_ready;
  logic        d_dout;
  logic        d_busy;
  ser_state_t  d_state;

  int n_cmp;
  int n_bad;
  int n_xfer;

  ws2812_serializer #(
    .T0H(S_T0H), .T1H(S_T1H), .TBIT(S_TBIT), .TLATCH(S_TLATCH), .CW(4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .dout        (dout),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  ws2812_serializer u_def (
    .clk         (clk),
    .reset       (reset),
    .pixel_data  (d_data),
    .pixel_valid (d_valid),
    .pixel_ready (d_ready),
    .dout        (d_dout),
    .busy        (d_busy),
    .dbg_state   (d_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on an IDLE falling edge: offer w, let the next rising edge take it.
  task automatic start_word(input logic [23:0] w, input bit keep, input logic [23:0] nxt);
    pixel_data  = w;
    pixel_valid = 1'b1;
    chk("start ready", pixel_ready, 1);
    if (pixel_ready) n_xfer++;
    @(negedge clk);
    if (keep) pixel_data = nxt;
    else      pixel_valid = 1'b0;
    chk("accept dout", dout, 0);
    chk("accept busy", busy, 1);
    chk("accept state", dbg_state, SEND);
  endtask

  // 144 cycles of dout for word w; ready expected only on bit 0's last count.
  task automatic check_word(input logic [23:0] w, input string name);
    for (int m = 0; m < WORD_CYC; m++) begin
      int b;
      int j;
      b = 23 - m / S_TBIT;
      j = m % S_TBIT;
      @(negedge clk);
      chk($sformatf("%s dout bit%0d cyc%0d", name, b, j), dout,
          (j < (w[b] ? S_T1H : S_T0H)) ? 1 : 0);
      chk($sformatf("%s ready m%0d", name, m), pixel_ready, (m == WORD_CYC - 2) ? 1 : 0);
      chk($sformatf("%s busy m%0d", name, m), busy, 1);
      if (pixel_ready && pixel_valid) n_xfer++;
      if (m == WORD_CYC - 1) pixel_valid = 1'b0;
    end
  endtask

  // Latch period; with late=1 a word is offered one cycle into it and its
  // data is scrambled mid-latch to show it is ignored until IDLE.
  task automatic check_latch(input bit late, input logic [23:0] nw);
    for (int j = 0; j < S_TLATCH; j++) begin
      @(negedge clk);
      chk($sformatf("latch dout j%0d", j), dout, 0);
      chk($sformatf("latch ready j%0d", j), pixel_ready, (j == S_TLATCH - 1) ? 1 : 0);
      chk($sformatf("latch busy j%0d", j), busy, (j == S_TLATCH - 1) ? 0 : 1);
      if (late && j == 0) begin
        pixel_valid = 1'b1;
        pixel_data  = nw;
      end
      if (late && j == 4) pixel_data = ~nw;
      if (late && j == 8) pixel_data = nw;
    end
    chk("latch end state", dbg_state, IDLE);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_xfer = 0;
    reset = 1'b1;
    pixel_valid = 1'b1; pixel_data = 24'hFFFFFF;
    d_valid = 1'b1;     d_data = 24'hFFFFFF;

    // reset values with valid held high
    repeat (3) @(negedge clk);
    chk("rst ready", pixel_ready, 0);
    chk("rst dout", dout, 0);
    chk("rst busy", busy, 0);
    chk("rst state", dbg_state, IDLE);
    chk("rst d_ready", d_ready, 0);
    reset = 1'b0; pixel_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    chk("post-rst ready", pixel_ready, 1);
    chk("post-rst dout", dout, 0);
    chk("post-rst busy", busy, 0);

    // single word followed by latch
    start_word(24'hA50001, 1'b0, 24'h0);
    check_word(24'hA50001, "single");
    check_latch(1'b0, 24'h0);

    // back-to-back FFFFFF then 000000, then a late word during latch
    n_xfer = 0;
    start_word(24'hFFFFFF, 1'b1, 24'h000000);
    check_word(24'hFFFFFF, "b2b_ones");
    check_word(24'h000000, "b2b_zeros");
    chk("b2b transfers", n_xfer, 2);
    check_latch(1'b1, 24'h3C5A96);
    @(negedge clk);
    pixel_valid = 1'b0;
    chk("late accept dout", dout, 0);
    chk("late accept state", dbg_state, SEND);
    check_word(24'h3C5A96, "late");
    check_latch(1'b0, 24'h0);

    // reset during the high phase of bit 12
    start_word(24'h001000, 1'b0, 24'h0);
    for (int m = 0; m < 68; m++) begin
      int b;
      int j;
      b = 23 - m / S_TBIT;
      j = m % S_TBIT;
      @(negedge clk);
      chk($sformatf("part dout bit%0d cyc%0d", b, j), dout,
          (j < (24'h001000 >> b & 1 ? S_T1H : S_T0H)) ? 1 : 0);
    end
    reset = 1'b1;
    #1;
    chk("midrst dout", dout, 0);
    chk("midrst state", dbg_state, IDLE);
    chk("midrst busy", busy, 0);
    chk("midrst ready", pixel_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after midrst ready", pixel_ready, 1);
    chk("after midrst dout", dout, 0);
    start_word(24'hC3E187, 1'b0, 24'h0);
    check_word(24'hC3E187, "after_rst");
    check_latch(1'b0, 24'h0);

    // default timing instance: 24'h800000
    d_data = 24'h800000; d_valid = 1'b1;
    chk("def start ready", d_ready, 1);
    @(negedge clk);
    d_valid = 1'b0;
    chk("def accept state", d_state, SEND);
    for (int m = 0; m < 24 * 63; m++) begin
      int b;
      int j;
      b = 23 - m / 63;
      j = m % 63;
      @(negedge clk);
      chk($sformatf("def dout bit%0d cyc%0d", b, j), d_dout,
          (j < ((b == 23) ? 40 : 20)) ? 1 : 0);
    end
    for (int j = 0; j < 2500; j++) begin
      @(negedge clk);
      chk($sformatf("def latch dout j%0d", j), d_dout, 0);
      chk($sformatf("def latch ready j%0d", j), d_ready, (j == 2499) ? 1 : 0);
    end
    chk("def end busy", d_busy, 0);
    chk("def end state", d_state, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812_serializer.md
# ws2812_serializer

Single-wire LED serializer for WS2812-class pixel strips. It takes 24-bit pixel words over a valid/ready handshake and drives the strip data pin with pulse-width-encoded bits, MSB first. When no further pixel is available at the end of a word, it holds the line low for the latch (reset) period. It sits downstream of the frame/pixel source and is the last stage before the output pin.

## Interface
- `T0H`, 20: high-time of a `0` bit, in clock cycles.
- `T1H`, 40: high-time of a `1` bit, in clock cycles.
- `TBIT`, 63: total bit period, in clock cycles.
- `TLATCH`, 2500: low period that latches the strip, in clock cycles.
- `CW`, 12: internal counter width; must satisfy 2^CW > max(TBIT, TLATCH).
- `clk`  in  1  system clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `pixel_data`  in  24  pixel word; bit 23 is sent first; colour ordering is the caller's responsibility.
- `pixel_valid`  in  1  `pixel_data` is valid.
- `pixel_ready`  out  1  serializer accepts `pixel_data` this cycle.
- `dout`  out  1  strip data line (registered).
- `busy`  out  1  high in SEND or LATCH.

## Operation
- Clock: one clock, `clk`. Reset: `reset`, asynchronous, active-high.
- Legal parameters: 0 < T0H < T1H < TBIT. TLATCH ≥ 1. Elaboration fails otherwise.
- States: IDLE, SEND, LATCH.
- Reset values: state IDLE, `dout`=0, `busy`=0, counters 0. `pixel_ready` is forced to 0 while `reset` is high.
- Transfer: a transfer occurs when `pixel_valid && pixel_ready`. On a transfer the word is captured into a 24-bit shift register and `bit_idx` is set to 23.
- `pixel_ready` is high:
  - in IDLE;
  - in SEND on the final cycle of bit 0 (`bit_idx`==0, `cnt`==TBIT-1), which allows back-to-back pixels with no gap.
  - It is low at all other times, including throughout LATCH.
- IDLE → SEND on transfer. `cnt` ← 0.
- SEND:
  - `cnt` counts 0..TBIT-1, then wraps.
  - Next-state `dout` = (`cnt` < (current bit ? T1H : T0H)).
  - On wrap with `bit_idx`>0: shift and decrement `bit_idx`.
  - On wrap with `bit_idx`==0:
    - transfer in the same cycle → reload and stay in SEND;
    - no transfer → LATCH, with `cnt` ← 0.
- LATCH: `dout`=0. `cnt` counts 0..TLATCH-1; on the final count → IDLE.
- Changes to `pixel_data` while `pixel_ready`=0 have no effect.
- Reset mid-word or mid-latch:
  - `dout` drops to 0 asynchronously and the partial word is discarded.
  - No latch period is generated. The downstream strip relies on the ≥TLATCH low time that follows naturally.

## Timing
- Transfer on rising edge k (in IDLE): `dout` rises at edge k+1. Bit 23 occupies edges k+1 .. k+TBIT.
- One pixel lasts 24·TBIT cycles on `dout`. A `1` bit is high for exactly T1H cycles, a `0` bit for exactly T0H cycles.
- Back-to-back pixels: bit 23 of the next word starts on the cycle immediately after bit 0's last cycle, with zero idle cycles.
- Latch: `dout` is low for exactly TLATCH cycles after the last bit's low phase. `pixel_ready` returns high on the first IDLE cycle.
- `busy` is registered alongside state: high from edge k+1 until the LATCH→IDLE edge.
- Throughput: one word per 24·TBIT cycles while streaming.

## Structure
- Shared package `led_pkg`:
  - state enum `ser_state_t` {IDLE, SEND, LATCH};
  - default timing constants `WS_T0H`, `WS_T1H`, `WS_TBIT`, `WS_TLATCH` (50 MHz values);
  - `PIXEL_W`=24.
- Sub-module `led_period_timer` (CW-bit):
  - inputs: `clk`, `reset`, `clear`, `ceiling`;
  - output: `wrap`, asserted on `cnt`==`ceiling`;
  - wraps to 0 after `ceiling`;
  - instantiated once, with `ceiling` muxed between TBIT-1 and TLATCH-1 by state.
- Top level holds the FSM, shift register, `bit_idx` (5 bits), and the `dout` register.

## Test plan
Bench parameters unless noted: T0H=2, T1H=4, TBIT=6, TLATCH=10.
- **Reset values:** hold `reset` high with `pixel_valid`=1 → `pixel_ready`=0, `dout`=0, `busy`=0. Release → `pixel_ready`=1 in the next cycle.
- **Single word:** send 24'hA50001 → `dout` high pulses of 4,2,4,2,2,4,2,4 cycles, then ... ending in a 4-cycle pulse for bit 0. Each period is 6 cycles, total 144 cycles. Then 10 low cycles, then `pixel_ready`=1.
- **Back-to-back:** hold `pixel_valid` high with words 24'hFFFFFF then 24'h000000 → 24 pulses of 4 cycles, then 24 pulses of 2 cycles, no gap. Exactly two transfers occur, with `pixel_ready` pulsing for one cycle between them.
- **Late valid:** assert `pixel_valid` 1 cycle after bit 0 ends → no transfer until LATCH completes. `dout` stays low for 10 cycles, then the word is accepted in IDLE.
- **Reset mid-word:** assert `reset` during bit 12 while `dout`=1 → `dout`=0 within the same cycle, state IDLE. The next word is serialized correctly from bit 23.
- **Default parameters:** 24'h800000 → first pulse high for 40 cycles, remaining 23 pulses high for 20 cycles each, period 63 cycles, latch 2500 cycles.
